// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, frame constants and divisor helper for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clocks per serial bit, rounded to the nearest integer
  function automatic int uart_div(input int clock_freq, input int baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/level and same-cycle push+pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH %0d must be a power of two in 2..256", DEPTH);
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A push into a full FIFO still lands when the head leaves in the same cycle
  always_comb begin
    do_pop   = pop_i & ~empty_q;
    do_push  = push_i & (~full_q | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Pointer and occupancy registers; flags are precomputed so they leave as flops
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed serialiser
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 25125000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          RSTb,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx
);

  localparam int DIV = uart_div(CLOCK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: baud divisor %0d is below 2", DIV);
  end

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (RSTb),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Frame sequencing: every bit boundary reloads the baud counter, and tx_d is the
  // line level for the coming cycle so the pin comes straight off a flop
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_head;
          baud_cnt_d = BAUD_RELOAD;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - CW'(1);
        end else begin
          baud_cnt_d = BAUD_RELOAD;
          bit_idx_d  = '0;
          state_d    = DATA;
          tx_d       = shift_q[0];
        end
      end
      DATA: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - CW'(1);
        end else begin
          baud_cnt_d = BAUD_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - CW'(1);
        end else if (!fifo_empty) begin
          // Chain straight into the next start bit with no idle gap
          pop        = 1'b1;
          shift_d    = fifo_head;
          baud_cnt_d = BAUD_RELOAD;
          state_d    = START;
          tx_d       = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
    overflow_d = wr_en & fifo_full & ~pop;
  end

  // Serialiser state; reset abandons any frame in flight and parks the line high
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue-and-timer reference model
module tb_uart_tx_fifo;

  localparam int CF    = 1000000;
  localparam int BR    = 100000;
  localparam int DEPTH = 4;
  localparam int DIV   = (CF + BR / 2) / BR;
  localparam int FRAME = 10 * DIV;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          RSTb = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, busy, overflow, tx;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLOCK_FREQ (CF),
    .BAUD_RATE  (BR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .RSTb     (RSTb),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte queue plus "cycles left in the current frame"
  logic [7:0] mq[$];
  logic [7:0] m_acc[$];
  int         m_left = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;

  // Decoder output: bytes seen on tx, cycle of each start bit, framing errors
  logic [7:0] dec_q[$];
  longint     dec_start[$];
  int         dec_ferr = 0;
  longint     cyc = 0;

  function automatic logic m_tx();
    int e;
    int b;
    if (m_left == 0) return 1'b1;
    e = FRAME - m_left;
    b = e / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic model_step();
    bit pop;
    bit acc;
    if (RSTb !== 1'b1) begin
      mq.delete();
      m_left = 0;
      m_ovf  = 1'b0;
      return;
    end
    pop   = (m_left <= 1) && (mq.size() > 0);
    acc   = wr_en && ((mq.size() < DEPTH) || pop);
    m_ovf = wr_en && !acc;
    if (pop) begin
      m_cur  = mq.pop_front();
      m_left = FRAME;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (acc) begin
      mq.push_back(wr_data);
      m_acc.push_back(wr_data);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int t;
    t = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && t < lim) begin
      tick();
      t++;
    end
    ok = (busy === 1'b0 && empty === 1'b1);
  endtask

  task automatic clear_logs();
    dec_q.delete();
    dec_start.delete();
    m_acc.delete();
  endtask

  // Line decoder: samples each bit at its midpoint after spotting a start edge
  initial begin
    int c;
    int b;
    bit act;
    logic [7:0] sh;
    act = 1'b0;
    c   = 0;
    sh  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (RSTb !== 1'b1) begin
        act = 1'b0;
        continue;
      end
      if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          c   = 0;
          dec_start.push_back(cyc);
        end
      end else begin
        c++;
      end
      if (act && (c % DIV) == DIV / 2) begin
        b = c / DIV;
        if (b >= 1 && b <= 8) begin
          sh[b-1] = tx;
        end else if (b == 9) begin
          if (tx === 1'b1) dec_q.push_back(sh);
          else dec_ferr++;
          act = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    RSTb = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'($urandom());
    repeat (3) tick();
    wr_en = 1'b0;
    n_vec++; if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (level !== '0)      begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    RSTb = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    logic [7:0] pat;
    logic       exp;
    bit         ok;
    pat = 8'h55;
    clear_logs();
    wr_en = 1'b1;
    wr_data = pat;
    tick();
    wr_en = 1'b0;
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty_after_write: got %b want 0", empty); end
    n_vec++; if (level !== LW'(1)) begin n_err++; $display("FAIL single_level_after_write: got %0d want 1", level); end
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_tx_before_pop: got %b want 1", tx); end
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      if (i <= DIV) exp = 1'b0;
      else if (i > 9 * DIV) exp = 1'b1;
      else exp = pat[(i - DIV - 1) / DIV];
      n_vec++; if (tx !== exp) begin n_err++; $display("FAIL single_tx cycle %0d: got %b want %b", i, tx, exp); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy cycle %0d: got %b want 1", i, busy); end
    end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_end: got %b want 1", empty); end
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_tx_end: got %b want 1", tx); end
    n_vec++;
    if (dec_q.size() != 1 || dec_q[0] !== pat) begin
      n_err++; $display("FAIL single_decoded: got %0d bytes first %h want 1 byte %h", dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx, pat);
    end
    wait_idle(10, ok);
  endtask

  task automatic test_back_to_back();
    int  t;
    bit  ok;
    logic exp;
    clear_logs();
    wr_en = 1'b1; wr_data = 8'hA5; tick();
    wr_data = 8'h3C; tick();
    wr_en = 1'b0;
    t = 0;
    while (dec_q.size() < 2 && t < 4 * FRAME) begin
      tick();
      t++;
      exp = m_tx();
      n_vec++; if (tx !== exp) begin n_err++; $display("FAIL b2b_tx cycle %0d: got %b want %b", t, tx, exp); end
    end
    n_vec++; if (dec_q.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d frames want 2 (timeout)", dec_q.size()); end
    n_vec++; if (dec_q.size() < 1 || dec_q[0] !== 8'hA5) begin n_err++; $display("FAIL b2b_byte0: got %h want a5", (dec_q.size() > 0) ? dec_q[0] : 8'hxx); end
    n_vec++; if (dec_q.size() < 2 || dec_q[1] !== 8'h3C) begin n_err++; $display("FAIL b2b_byte1: got %h want 3c", (dec_q.size() > 1) ? dec_q[1] : 8'hxx); end
    n_vec++;
    if (dec_start.size() < 2 || dec_start[1] - dec_start[0] != longint'(FRAME)) begin
      n_err++; $display("FAIL b2b_gap: got %0d cycles between starts want %0d", (dec_start.size() > 1) ? dec_start[1] - dec_start[0] : -1, FRAME);
    end
    wait_idle(2 * FRAME, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_idle: busy %b empty %b want 0/1", busy, empty); end
  endtask

  task automatic test_overflow();
    bit         ok;
    logic [7:0] got;
    clear_logs();
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      if (i == 5) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
        n_vec++; if (level !== LW'(4)) begin n_err++; $display("FAIL ovf_level_peak: got %0d want 4", level); end
      end
      n_vec++;
      if (overflow !== (i == 6)) begin n_err++; $display("FAIL ovf_pulse write %0d: got %b want %b", i, overflow, (i == 6)); end
    end
    wr_en = 1'b0;
    n_vec++; if (level !== LW'(4)) begin n_err++; $display("FAIL ovf_level_after_drop: got %0d want 4", level); end
    tick();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pulse_width: got %b want 0", overflow); end
    wait_idle(6 * FRAME, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_idle: busy %b empty %b want 0/1", busy, empty); end
    n_vec++; if (dec_q.size() != 5) begin n_err++; $display("FAIL ovf_count: got %0d frames want 5", dec_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < dec_q.size()) ? dec_q[i] : 8'hxx;
      n_vec++; if (got !== 8'(i + 1)) begin n_err++; $display("FAIL ovf_order idx %0d: got %h want %h", i, got, 8'(i + 1)); end
    end
  endtask

  task automatic test_full_pop();
    bit         ok;
    logic [7:0] b[5];
    logic [7:0] got;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom());
      wr_en = 1'b1;
      wr_data = b[i];
      tick();
    end
    wr_en = 1'b0;
    repeat (96) tick();
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fullpop_full_before: got %b want 1", full); end
    wr_en = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
    n_vec++; if (level !== LW'(4)) begin n_err++; $display("FAIL fullpop_level: got %0d want 4", level); end
    n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL fullpop_next_start: got %b want 0", tx); end
    wait_idle(6 * FRAME, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fullpop_idle: busy %b empty %b want 0/1", busy, empty); end
    n_vec++; if (dec_q.size() != 6) begin n_err++; $display("FAIL fullpop_count: got %0d frames want 6", dec_q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < dec_q.size()) ? dec_q[i] : 8'hxx;
      n_vec++;
      if (got !== ((i < 5) ? b[i] : 8'h77)) begin
        n_err++; $display("FAIL fullpop_order idx %0d: got %h want %h", i, got, (i < 5) ? b[i] : 8'h77);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    int ferr0;
    clear_logs();
    ferr0 = dec_ferr;
    wr_en = 1'b1; wr_data = 8'hF0; tick();
    wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    wr_en = 1'b0;
    repeat (42) tick();
    n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL midrst_bit3: got %b want 0", tx); end
    n_vec++; if (level !== LW'(2)) begin n_err++; $display("FAIL midrst_queued: got %0d want 2", level); end
    RSTb = 1'b0;
    tick();
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx: got %b want 1", tx); end
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL midrst_level: got %0d want 0", level); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %b want 1", empty); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    RSTb = 1'b1;
    lows = 0;
    repeat (3 * FRAME) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_vec++; if (lows != 0) begin n_err++; $display("FAIL midrst_quiet: got %0d active cycles want 0", lows); end
    n_vec++; if (dec_q.size() != 0) begin n_err++; $display("FAIL midrst_frames: got %0d frames want 0", dec_q.size()); end
    n_vec++; if (dec_ferr != ferr0) begin n_err++; $display("FAIL midrst_framing: got %0d errors want %0d", dec_ferr, ferr0); end
  endtask

  task automatic test_random();
    int         thr;
    bit         ok;
    logic       exp_tx;
    logic [7:0] got;
    clear_logs();
    thr = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) thr = (($urandom() & 1) != 0) ? 60 : int'($urandom_range(1, 12));
      wr_en = ($urandom_range(0, 99) < thr);
      wr_data = 8'($urandom());
      tick();
      exp_tx = m_tx();
      n_vec++; if (tx !== exp_tx) begin n_err++; $display("FAIL rand_tx cycle %0d: got %b want %b", i, tx, exp_tx); end
      n_vec++; if (busy !== (m_left > 0)) begin n_err++; $display("FAIL rand_busy cycle %0d: got %b want %b", i, busy, (m_left > 0)); end
      n_vec++; if (level !== LW'(mq.size())) begin n_err++; $display("FAIL rand_level cycle %0d: got %0d want %0d", i, level, mq.size()); end
      n_vec++; if (empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rand_empty cycle %0d: got %b want %b", i, empty, (mq.size() == 0)); end
      n_vec++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rand_full cycle %0d: got %b want %b", i, full, (mq.size() == DEPTH)); end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rand_overflow cycle %0d: got %b want %b", i, overflow, m_ovf); end
    end
    wr_en = 1'b0;
    wait_idle((DEPTH + 2) * FRAME, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rand_idle: busy %b empty %b want 0/1", busy, empty); end
    n_vec++; if (dec_q.size() != m_acc.size()) begin n_err++; $display("FAIL rand_count: got %0d frames want %0d", dec_q.size(), m_acc.size()); end
    for (int i = 0; i < m_acc.size(); i++) begin
      got = (i < dec_q.size()) ? dec_q[i] : 8'hxx;
      n_vec++; if (got !== m_acc[i]) begin n_err++; $display("FAIL rand_byte idx %0d: got %h want %h", i, got, m_acc[i]); end
    end
    n_vec++; if (dec_ferr != 0) begin n_err++; $display("FAIL rand_framing: got %0d errors want 0", dec_ferr); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter that drives the board UART_TX pin (PINS[15]) on the iCE40 build.
- The slurm16 port-write logic pushes bytes into an internal FIFO. A baud-timed FSM serialises them onto tx.
- It runs in the single PLL clock domain (clk, 25.125 MHz on iCE40). Its reset is the same RSTb the top-level reset counter produces.

Parameters:
- CLOCK_FREQ, 25125000, clk frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in Hz.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- RSTb  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds FIFO_DEPTH entries (registered).
- empty  output  1  FIFO holds 0 entries (registered).
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  output  1  FSM not IDLE.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset: while RSTb=0 at an edge, all of the following hold.
  - FIFO is flushed: level=0, empty=1, full=0.
  - FSM goes to IDLE; busy=0, overflow=0, tx=1.
  - Baud counter and bit counter are cleared.
  - A reset mid-frame aborts the frame: tx=1 after that edge, and the byte is lost.
- Divisor: DIV = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE, integer rounding to nearest.
  - 218 at the defaults.
  - Elaboration error if DIV < 2.
- FIFO write rules:
  - A write is accepted when wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - When wr_en=1, full=1 and no pop occurs, the byte is dropped and overflow=1 for exactly that following cycle.
  - A simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly FIFO.
- FSM states and transitions:
  - IDLE: tx=1. If empty=0: pop the head into shift_reg, load baud_cnt=DIV-1, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[0], LSB first. Each bit lasts DIV cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for DIV cycles. At expiry, if empty=0, pop and go directly to START (no idle gap); else go to IDLE.
- Baud timing:
  - baud_cnt down-counts from DIV-1; the state/bit advances when baud_cnt==0.
  - The counter reloads on every bit boundary, so there is no cumulative drift within a frame.
- Latency:
  - wr_en sampled at edge k into an empty FIFO with the FSM in IDLE → empty=0 after edge k → pop at edge k+1 → tx=0 after edge k+1.
  - Frame length is exactly 10·DIV cycles.
  - No bypass path: every byte goes through the FIFO.
- Output registration:
  - tx is driven from a register with no combinational path from wr_en.
  - busy=1 from the pop edge through the last STOP cycle.
- Writes during an active frame never disturb shift_reg or tx.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1;
  - a function computing DIV from CLOCK_FREQ/BAUD_RATE.
- One sub-module, sync_fifo: parameterised width/depth, with full/empty/level registered and simultaneous push/pop support.
- The top-level instantiates sync_fifo plus the FSM/baud logic inline.

Test Plan:
- All scenarios use CLOCK_FREQ=1000000 and BAUD_RATE=100000, giving DIV=10.
- Reset: hold RSTb=0 for 3 cycles → tx=1, busy=0, empty=1, level=0, overflow=0.
- Single byte: write 0x55 at edge k.
  - tx=0 at cycles k+1..k+10.
  - Bits 1,0,1,0,1,0,1,0 at 10 cycles each.
  - Stop high for 10 cycles.
  - busy drops after 100 cycles total; empty=1.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles.
  - The second start bit begins on the cycle immediately after the first stop bit ends.
  - Decoded bytes are 0xA5 then 0x3C.
- Overflow: with FIFO_DEPTH=4, write 0x01..0x06 on 6 consecutive cycles from idle.
  - The first is popped, so 0x01..0x05 are accepted; level peaks at 4 and full=1.
  - The 6th write gives a 1-cycle overflow pulse.
  - 0x01..0x05 are transmitted in order; 0x06 never appears.
- Full+pop: fill to full=1, then write 0x77 on the STOP→START pop cycle → accepted, no overflow, level stays 4, and 0x77 is transmitted last.
- Reset mid-frame: assert RSTb=0 during DATA bit 3 of 0xF0 with 2 bytes queued → tx=1 next cycle, level=0, and no further frames after reset is released.
